// File: rtl/mac_inv_pkg.sv
// -----------------------------------------------------------------------------
// mac_inv_pkg
//   Shared constants and types for the MAC inverse divider.
//   - AW_DEF / PW_DEF : default operand and result widths
//   - CNT_W           : width of the divider bit counter for the default PW
//   - state_t         : controller FSM states
// -----------------------------------------------------------------------------
package mac_inv_pkg;

  localparam int AW_DEF = 18;
  localparam int PW_DEF = 48;
  localparam int CNT_W  = $clog2(PW_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mac_inv_div_core.sv
// -----------------------------------------------------------------------------
// mac_inv_div_core
//   Unsigned restoring divider, one quotient bit per step, MSB first.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     load     : clear remainder/quotient, set counter to PW-1
//     step     : perform one restoring step on bit num[cnt]
//     num      : numerator (held stable by the caller during the division)
//     div      : divisor, AW+1 bits (held stable during the division)
//     last     : high while the step being presented is the final one (cnt==0)
//     quot     : quotient register
//     rem      : remainder register
// -----------------------------------------------------------------------------
module mac_inv_div_core
  import mac_inv_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF,
  parameter int CW = $clog2(PW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [PW-1:0] num,
  input  logic [AW:0]   div,
  output logic          last,
  output logic [PW-1:0] quot,
  output logic [AW:0]   rem
);

  // Remainder is always < div (fits AW+1 bits); the extra bit holds the
  // shifted-in value before the trial subtraction.
  logic [AW+1:0] r;
  logic [PW-1:0] q;
  logic [CW-1:0] cnt;

  logic [AW+1:0] r_shift;
  logic [AW+1:0] r_sub;
  logic          fits;

  always_comb begin
    r_shift = (r << 1) | {{(AW+1){1'b0}}, num[cnt]};
    fits    = (r_shift >= {1'b0, div});
    r_sub   = r_shift - {1'b0, div};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r   <= '0;
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      r   <= '0;
      q   <= '0;
      cnt <= CW'(PW-1);
    end else if (step) begin
      r      <= fits ? r_sub : r_shift;
      q[cnt] <= fits;
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign last = (cnt == '0);
  assign quot = q;
  assign rem  = r[AW:0];

endmodule

// File: rtl/mac_inverse_divider.sv
// -----------------------------------------------------------------------------
// mac_inverse_divider
//   Recovers A = (P - C) / (D + B) with remainder from a pre-add/multiply/
//   post-add MAC result, using a bit-serial restoring divider.
//   Optional feature macro: MAC_INV_RANGE_CHECK_EN adds the a_ovf output.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     start     : request, sampled only when idle
//     p_in/c_in : MAC result P and post-adder operand C (PW bits)
//     b_in/d_in : pre-adder operands (AW bits)
//     busy      : high from accepted start until done
//     done      : one-cycle pulse, results valid and then held
//     quot/rem  : quotient (PW bits) and remainder (AW+1 bits)
//     err_div0  : D+B == 0
//     err_neg   : P < C
//     a_ovf     : quotient does not fit in AW bits (range-check build only)
// -----------------------------------------------------------------------------
module mac_inverse_divider
  import mac_inv_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] p_in,
  input  logic [PW-1:0] c_in,
  input  logic [AW-1:0] b_in,
  input  logic [AW-1:0] d_in,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] quot,
  output logic [AW:0]   rem,
  output logic          err_div0,
  output logic          err_neg
`ifdef MAC_INV_RANGE_CHECK_EN
  ,
  output logic          a_ovf
`endif
);

  state_t state, state_next;

  logic [PW-1:0] p_cap, c_cap;
  logic [AW-1:0] b_cap, d_cap;

  // Error causes latched in PREP, published together with done.
  logic pend_div0, pend_neg;

  logic [PW-1:0] num;
  logic [AW:0]   sum;
  logic          is_div0, is_neg;

  logic accept, core_load, core_step, finish;

  logic          core_last;
  logic [PW-1:0] core_quot;
  logic [AW:0]   core_rem;

  always_comb begin
    num     = p_cap - c_cap;
    sum     = {1'b0, b_cap} + {1'b0, d_cap};
    is_div0 = (sum == '0);
    is_neg  = (p_cap < c_cap);
  end

  mac_inv_div_core #(
    .AW (AW),
    .PW (PW)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (core_load),
    .step (core_step),
    .num  (num),
    .div  (sum),
    .last (core_last),
    .quot (core_quot),
    .rem  (core_rem)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and control strobes
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    core_load  = 1'b0;
    core_step  = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = PREP;
        end
      end
      PREP: begin
        if (is_div0 || is_neg) begin
          state_next = DONE;
        end else begin
          core_load  = 1'b1;
          state_next = DIV;
        end
      end
      DIV: begin
        core_step = 1'b1;
        if (core_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Input capture and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_cap     <= '0;
      c_cap     <= '0;
      b_cap     <= '0;
      d_cap     <= '0;
      pend_div0 <= 1'b0;
      pend_neg  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      err_div0  <= 1'b0;
      err_neg   <= 1'b0;
`ifdef MAC_INV_RANGE_CHECK_EN
      a_ovf     <= 1'b0;
`endif
    end else begin
      done <= finish;
      if (accept) begin
        p_cap     <= p_in;
        c_cap     <= c_in;
        b_cap     <= b_in;
        d_cap     <= d_in;
        pend_div0 <= 1'b0;
        pend_neg  <= 1'b0;
        busy      <= 1'b1;
        err_div0  <= 1'b0;
        err_neg   <= 1'b0;
`ifdef MAC_INV_RANGE_CHECK_EN
        a_ovf     <= 1'b0;
`endif
      end
      if (state == PREP) begin
        pend_div0 <= is_div0;
        pend_neg  <= is_neg;
      end
      if (finish) begin
        busy     <= 1'b0;
        err_div0 <= pend_div0;
        err_neg  <= pend_neg;
        if (pend_div0 || pend_neg) begin
          quot <= '0;
          rem  <= '0;
        end else begin
          quot <= core_quot;
          rem  <= core_rem;
        end
`ifdef MAC_INV_RANGE_CHECK_EN
        // Any set bit above AW-1 means the result is not a legal A operand.
        a_ovf <= !(pend_div0 || pend_neg) && (core_quot[PW-1:AW] != '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_mac_inverse_divider.sv
// -----------------------------------------------------------------------------
// tb_mac_inverse_divider
//   Directed self-checking bench for mac_inverse_divider (AW=18, PW=48).
//   Range-check tests are compiled only with MAC_INV_RANGE_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_mac_inverse_divider;

  localparam int AW = 18;
  localparam int PW = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [PW-1:0] p_in, c_in;
  logic [AW-1:0] b_in, d_in;
  logic          busy, done;
  logic [PW-1:0] quot;
  logic [AW:0]   rem;
  logic          err_div0, err_neg;
`ifdef MAC_INV_RANGE_CHECK_EN
  logic          a_ovf;
`endif

  int total  = 0;
  int passed = 0;

  mac_inverse_divider #(.AW(AW), .PW(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .p_in     (p_in),
    .c_in     (c_in),
    .b_in     (b_in),
    .d_in     (d_in),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .err_div0 (err_div0),
    .err_neg  (err_neg)
`ifdef MAC_INV_RANGE_CHECK_EN
    ,
    .a_ovf    (a_ovf)
`endif
  );

  always #1 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Issues one request and returns the number of clock edges from the
  // accepting edge to the edge that raised done (-1 on timeout).
  task automatic run_op(input logic [PW-1:0] p, input logic [PW-1:0] c,
                        input logic [AW-1:0] b, input logic [AW-1:0] d,
                        output int lat, output logic busy_seen);
    @(negedge clk);
    p_in  = p;
    c_in  = c;
    b_in  = b;
    d_in  = d;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    busy_seen = busy;
    lat       = -1;
    for (int j = 1; j <= 200; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = j;
        break;
      end
    end
    $display("op P=%0d C=%0d B=%0d D=%0d -> lat=%0d quot=%0d rem=%0d div0=%0b neg=%0b",
             p, c, b, d, lat, quot, rem, err_div0, err_neg);
  endtask

  initial begin
    int            lat;
    logic          bsy;
    int            ndone;
    int            first;
    logic [63:0]   s_wide;

    // 1. Reset with start held high
    rst   = 1'b1;
    start = 1'b1;
    p_in  = 48'd88;
    c_in  = 48'd8;
    b_in  = 18'd5;
    d_in  = 18'd3;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_div0", err_div0, 0);
    check("rst_neg", err_neg, 0);
    rst   = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // 2. Basic divisions
    run_op(48'd88, 48'd8, 18'd5, 18'd3, lat, bsy);
    check("t2a_busy", bsy, 1);
    check("t2a_lat", 64'(lat), 50);
    check("t2a_quot", quot, 10);
    check("t2a_rem", rem, 0);
    check("t2a_div0", err_div0, 0);
    check("t2a_neg", err_neg, 0);
    check("t2a_busy_at_done", busy, 0);
    @(negedge clk);
    check("t2a_done_pulse", done, 0);
    check("t2a_quot_hold", quot, 10);

    run_op(48'd1160, 48'd12, 18'd50, 18'd32, lat, bsy);
    check("t2b_lat", 64'(lat), 50);
    check("t2b_quot", quot, 14);
    check("t2b_rem", rem, 0);

    // 3. Remainders and extremes
    run_op(48'd89, 48'd8, 18'd5, 18'd3, lat, bsy);
    check("t3a_quot", quot, 10);
    check("t3a_rem", rem, 1);

    run_op(48'hFFFF_FFFF_FFFF, 48'd0, 18'd1, 18'd0, lat, bsy);
    check("t3b_quot", quot, 64'h0000_FFFF_FFFF_FFFF);
    check("t3b_rem", rem, 0);

    run_op(48'd1000, 48'd100, 18'd7, 18'd6, lat, bsy);
    check("t3c_quot", quot, 69);
    check("t3c_rem", rem, 3);

    run_op(48'd777, 48'd777, 18'd9, 18'd4, lat, bsy);
    check("t3d_p_eq_c_neg", err_neg, 0);
    check("t3d_p_eq_c_quot", quot, 0);
    check("t3d_p_eq_c_lat", 64'(lat), 50);

    // Largest divisor: S = 2*(2^18-1) = 524286, check the division identity
    run_op(48'hFFFF_FFFF_FFFF, 48'd0, 18'h3FFFF, 18'h3FFFF, lat, bsy);
    s_wide = 64'd524286;
    check("t3e_identity", (64'(quot) * s_wide) + 64'(rem), 64'h0000_FFFF_FFFF_FFFF);
    check("t3e_rem_lt_s", 64'(64'(rem) < s_wide), 1);

    // 4. Error paths
    run_op(48'd100, 48'd0, 18'd0, 18'd0, lat, bsy);
    check("t4a_lat", 64'(lat), 2);
    check("t4a_div0", err_div0, 1);
    check("t4a_neg", err_neg, 0);
    check("t4a_quot", quot, 0);
    check("t4a_rem", rem, 0);

    run_op(48'd5, 48'd8, 18'd1, 18'd1, lat, bsy);
    check("t4b_lat", 64'(lat), 2);
    check("t4b_div0", err_div0, 0);
    check("t4b_neg", err_neg, 1);

    run_op(48'd5, 48'd8, 18'd0, 18'd0, lat, bsy);
    check("t4c_div0", err_div0, 1);
    check("t4c_neg", err_neg, 1);

    // Flags clear on the next good request
    run_op(48'd88, 48'd8, 18'd5, 18'd3, lat, bsy);
    check("t4d_div0_clr", err_div0, 0);
    check("t4d_neg_clr", err_neg, 0);
    check("t4d_quot", quot, 10);

    // 5a. Start while busy is ignored, not queued
    @(negedge clk);
    p_in  = 48'd1000;
    c_in  = 48'd100;
    b_in  = 18'd7;
    d_in  = 18'd6;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    first = -1;
    for (int j = 1; j <= 120; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 10) begin
        p_in  = 48'd88;
        c_in  = 48'd8;
        b_in  = 18'd5;
        d_in  = 18'd3;
        start = 1'b1;
      end else if (j == 11) begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (first < 0) first = j;
      end
    end
    $display("busy-start test: dones=%0d first=%0d quot=%0d rem=%0d", ndone, first, quot, rem);
    check("t5a_ndone", 64'(ndone), 1);
    check("t5a_lat", 64'(first), 50);
    check("t5a_quot", quot, 69);
    check("t5a_rem", rem, 3);

    // 5b. Reset in the middle of a division
    @(negedge clk);
    p_in  = 48'hFFFF_FFFF_FFFF;
    c_in  = 48'd0;
    b_in  = 18'd1;
    d_in  = 18'd0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    $display("mid-op reset: busy=%0b done=%0b quot=%0d rem=%0d", busy, done, quot, rem);
    check("t5b_busy", busy, 0);
    check("t5b_done", done, 0);
    check("t5b_quot", quot, 0);
    check("t5b_rem", rem, 0);
    rst   = 1'b0;
    ndone = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t5b_no_done", 64'(ndone), 0);
    check("t5b_idle", busy, 0);

    run_op(48'd89, 48'd8, 18'd5, 18'd3, lat, bsy);
    check("t5c_lat", 64'(lat), 50);
    check("t5c_quot", quot, 10);
    check("t5c_rem", rem, 1);

`ifdef MAC_INV_RANGE_CHECK_EN
    // 6. Range check
    run_op(48'd2097160, 48'd8, 18'd8, 18'd0, lat, bsy);
    check("t6a_quot", quot, 262144);
    check("t6a_ovf", a_ovf, 1);

    run_op(48'd2097152, 48'd8, 18'd8, 18'd0, lat, bsy);
    check("t6b_quot", quot, 262143);
    check("t6b_ovf", a_ovf, 0);

    run_op(48'hFFFF_FFFF_FFFF, 48'd0, 18'd1, 18'd0, lat, bsy);
    check("t6c_ovf", a_ovf, 1);
    run_op(48'd5, 48'd8, 18'd0, 18'd0, lat, bsy);
    check("t6d_ovf_err", a_ovf, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
